// File: rtl/mem_bus_ctrl.sv
// Data-side bus controller: turns CPU byte/half/word loads and stores into
// word-wide accesses on a synchronous SRAM, with lane steering and wait states.
module mem_bus_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        ctrl,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              err,
    output logic              busy,
    output logic              sram_en,
    output logic              sram_we,
    output logic [3:0]        sram_be,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RDATA} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [ADDR_W+1:0] a_addr;
    logic [31:0]       a_wdata;
    logic [3:0]        a_ctrl;
    logic              latch_en;
    logic              ready_nxt, err_nxt, load_done;
    logic              misaligned;
    logic [3:0]        lane_be;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_fmt;

    // Address bits above the SRAM word address alias onto the same words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    // ctrl = {we, half, byte, ext}; byte takes priority over half.
    assign misaligned = !ctrl[1] && ((ctrl[2] && addr[0]) || (!ctrl[2] && addr[1:0] != 2'b00));

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_en  = 1'b0;
        ready_nxt = 1'b0;
        err_nxt   = 1'b0;
        load_done = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (misaligned) begin
                        ready_nxt = 1'b1;
                        err_nxt   = 1'b1;
                    end else begin
                        latch_en = 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state_nxt = WAIT;
                            cnt_nxt   = CNT_INIT;
                        end else begin
                            state_nxt = ACCESS;
                        end
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = ACCESS;
                else             cnt_nxt   = cnt - 4'd1;
            end
            ACCESS: begin
                if (a_ctrl[3]) begin
                    ready_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                ready_nxt = 1'b1;
                load_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            a_addr  <= '0;
            a_wdata <= 32'd0;
            a_ctrl  <= 4'd0;
            rdata   <= 32'd0;
            ready   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ready <= ready_nxt;
            err   <= err_nxt;
            if (latch_en) begin
                a_addr  <= addr[ADDR_W+1:0];
                a_wdata <= wdata;
                a_ctrl  <= ctrl;
            end
            if (load_done) rdata <= ld_fmt;
        end
    end

    always_comb begin
        if (a_ctrl[1])      lane_be = 4'b0001 << a_addr[1:0];
        else if (a_ctrl[2]) lane_be = a_addr[1] ? 4'b1100 : 4'b0011;
        else                lane_be = 4'b1111;
    end

    always_comb begin
        if (a_ctrl[1])      sram_wdata = {4{a_wdata[7:0]}};
        else if (a_ctrl[2]) sram_wdata = {2{a_wdata[15:0]}};
        else                sram_wdata = a_wdata;
    end

    // Load formatting: pick the lane or halfword, then sign- or zero-extend.
    assign ld_byte = 8'(sram_rdata >> {a_addr[1:0], 3'b000});
    assign ld_half = a_addr[1] ? sram_rdata[31:16] : sram_rdata[15:0];

    always_comb begin
        if (a_ctrl[1])      ld_fmt = a_ctrl[0] ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
        else if (a_ctrl[2]) ld_fmt = a_ctrl[0] ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
        else                ld_fmt = sram_rdata;
    end

    assign busy      = (state != IDLE);
    assign sram_en   = (state == ACCESS);
    assign sram_we   = sram_en && a_ctrl[3];
    assign sram_be   = sram_en ? lane_be : 4'b0000;
    assign sram_addr = a_addr[ADDR_W+1:2];

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: a byte-array reference model predicts each
// response and SRAM access; monitors compare whenever the DUT presents one.
module tb_mem_bus_ctrl;

    localparam int ADDR_W = 10;
    localparam int W      = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req = 1'b0;
    logic [31:0]       addr = 32'd0;
    logic [31:0]       wdata = 32'd0;
    logic [3:0]        ctrl = 4'd0;
    logic [31:0]       rdata;
    logic              ready, err, busy;
    logic              sram_en, sram_we;
    logic [3:0]        sram_be;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata = 32'd0;

    mem_bus_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .wdata(wdata), .ctrl(ctrl),
        .rdata(rdata), .ready(ready), .err(err), .busy(busy),
        .sram_en(sram_en), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous SRAM attached to the DUT.
    logic [31:0] sram_mem [0:(1<<ADDR_W)-1];
    initial for (int i = 0; i < (1 << ADDR_W); i++) sram_mem[i] = 32'd0;
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    // Reference memory, byte addressed.
    logic [7:0] ref_mem [0:(4<<ADDR_W)-1];
    initial for (int i = 0; i < (4 << ADDR_W); i++) ref_mem[i] = 8'd0;

    typedef struct {logic e; logic [31:0] rd; int at;} resp_t;
    typedef struct {logic [ADDR_W-1:0] wa; logic we; logic [3:0] be; logic [31:0] wd; int at;} acc_t;
    resp_t resp_q[$];
    acc_t  acc_q[$];
    resp_t mrs;
    acc_t  mac;

    int errors = 0;
    int checks = 0;
    logic [31:0] rdata_exp = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [3:0] c);
        return c[1] ? 1 : (c[2] ? 2 : 4);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of its ready cycle.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] c, input bit junk);
        int n, off, e, lat, base;
        bit mis;
        logic [31:0] v, mask;
        acc_t ac;
        resp_t rs;
        check("busy_idle", {31'd0, busy}, 32'd0);
        n    = nbytes(c);
        off  = int'(a[1:0]);
        mis  = (off % n) != 0;
        base = int'(a[ADDR_W+1:0]);
        e    = cyc + 1;
        addr = a; wdata = d; ctrl = c; req = 1'b1;
        lat  = mis ? 1 : (c[3] ? W + 2 : W + 3);
        if (!mis) begin
            ac.wa = a[ADDR_W+1:2];
            ac.we = c[3];
            ac.be = 4'(((1 << n) - 1) << off);
            ac.wd = (n == 1) ? {4{d[7:0]}} : ((n == 2) ? {2{d[15:0]}} : d);
            ac.at = e + W;
            acc_q.push_back(ac);
            if (c[3]) begin
                for (int i = 0; i < n; i++) ref_mem[base + i] = d[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
                mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
                if (c[0] && n < 4 && v[8*n-1]) v = v | ~mask;
                rdata_exp = v;
            end
        end
        rs.e  = mis;
        rs.rd = rdata_exp;
        rs.at = e + lat - 1;
        resp_q.push_back(rs);
        @(posedge clk);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check("busy_active", {31'd0, busy}, 32'd1);
            if (junk) begin
                req  = 1'($urandom_range(0, 1));
                addr = $urandom;
                ctrl = 4'($urandom_range(0, 15));
            end else begin
                req = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_ready"}, {31'd0, ready}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_sram_en"}, {31'd0, sram_en}, 32'd0);
        check({tag, "_sram_we"}, {31'd0, sram_we}, 32'd0);
        check({tag, "_sram_be"}, {28'd0, sram_be}, 32'd0);
        check({tag, "_sram_addr"}, 32'(sram_addr), 32'd0);
        check({tag, "_sram_wdata"}, sram_wdata, 32'd0);
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (reset) begin
            if (ready || err) begin
                if (resp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready: got ready=%0b err=%0b required no response", ready, err);
                end else begin
                    mrs = resp_q.pop_front();
                    check("ready", {31'd0, ready}, 32'd1);
                    check("err", {31'd0, err}, {31'd0, mrs.e});
                    check("rdata", rdata, mrs.rd);
                    check("ready_cycle", cyc, mrs.at);
                end
            end
        end
    end

    // SRAM access monitor.
    always @(negedge clk) begin
        if (reset) begin
            if (sram_en) begin
                if (acc_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_sram_en: got addr=0x%0h required no access", sram_addr);
                end else begin
                    mac = acc_q.pop_front();
                    check("sram_addr", 32'(sram_addr), 32'(mac.wa));
                    check("sram_we", {31'd0, sram_we}, {31'd0, mac.we});
                    check("sram_be", {28'd0, sram_be}, {28'd0, mac.be});
                    if (mac.we) check("sram_wdata", sram_wdata, mac.wd);
                    check("sram_cycle", cyc, mac.at);
                end
            end else begin
                check("sram_idle_we_be", {27'd0, sram_we, sram_be}, 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] a;
        int gap;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // Reset mid-WAIT aborts the access without a ready pulse.
        addr = 32'h20; wdata = 32'hDEAD_BEEF; ctrl = 4'b0000; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("busy_wait", {31'd0, busy}, 32'd1);
        #1 reset = 1'b0;
        #1 check_all_zero("abort");
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);

        // Word store/load.
        issue(32'h10, 32'h1234_5678, 4'b1000, 1'b0);
        issue(32'h10, 32'h0, 4'b0000, 1'b0);
        check("lw_0x10_const", rdata_exp, 32'h1234_5678);

        // Byte and halfword lanes on 0x80FF7F01.
        issue(32'h0, 32'h80FF_7F01, 4'b1000, 1'b0);
        issue(32'h3, 32'h0, 4'b0011, 1'b0);
        check("lb_const", rdata_exp, 32'hFFFF_FF80);
        issue(32'h3, 32'h0, 4'b0010, 1'b0);
        check("lbu_const", rdata_exp, 32'h0000_0080);
        issue(32'h2, 32'h0, 4'b0101, 1'b0);
        check("lh_const", rdata_exp, 32'hFFFF_80FF);
        issue(32'h2, 32'h0, 4'b0100, 1'b0);
        check("lhu_const", rdata_exp, 32'h0000_80FF);
        issue(32'h2, 32'h1234_56AB, 4'b1010, 1'b0);
        issue(32'h0, 32'h0, 4'b0000, 1'b0);
        issue(32'h2, 32'h5555_BEEF, 4'b1100, 1'b0);
        issue(32'h0, 32'h0, 4'b0000, 1'b0);

        // Misaligned accesses.
        issue(32'h6, 32'h0, 4'b0000, 1'b0);
        issue(32'h5, 32'h0, 4'b0100, 1'b0);
        issue(32'h7, 32'h0, 4'b1000, 1'b1);

        // Random traffic with gaps, back-to-back requests and dropped pulses while busy.
        for (int t = 0; t < 400; t++) begin
            a = $urandom;
            a[ADDR_W+1:6] = '0;
            issue(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                gap = $urandom_range(1, 3);
                repeat (gap) @(negedge clk);
            end
        end

        repeat (8) @(negedge clk);
        check("resp_q_drained", resp_q.size(), 32'd0);
        check("acc_q_drained", acc_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
